// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 frame sequencer that drives an external N-bit LSB-first shifter.
// It produces SCLK, CS_n, the shifter load/shift enables and the MISO sample, all registered.
module spi_master_ctrl #(
    parameter int N       = 20,
    parameter int CLK_DIV = 4
) (
    input  logic i_clk_p,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_abort,
    input  logic i_miso,
    input  logic i_sh_bit,
    output logic o_sh_en,
    output logic o_sh_wrt,
    output logic o_sh_bit,
    output logic o_mosi,
    output logic o_sclk,
    output logic o_cs_n,
    output logic o_busy,
    output logic o_done
);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(N + 1);
    typedef enum logic [2:0] {IDLE, LOAD, SETUP, HIGH, LOW, HOLD} state_t;
    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          sclk_q, cs_n_q, busy_q, done_q, sh_en_q, sh_wrt_q, sh_bit_q;
    logic          last;
    assign last   = div_q == DW'(CLK_DIV - 1);
    assign o_mosi = i_sh_bit;
    always_comb begin
        state_d = state_q;
        div_d   = div_q + DW'(1);
        bit_d   = bit_q;
        case (state_q)
            IDLE: begin
                div_d   = '0;
                state_d = (i_start && !i_abort) ? LOAD : IDLE;
            end
            LOAD: begin
                div_d   = '0;
                bit_d   = '0;
                state_d = SETUP;
            end
            SETUP, LOW: begin
                div_d   = last ? '0 : div_d;
                state_d = last ? HIGH : state_q;
            end
            HIGH: begin
                div_d   = last ? '0 : div_d;
                bit_d   = last ? bit_q + BW'(1) : bit_q;
                state_d = !last ? HIGH : (bit_q == BW'(N - 1)) ? HOLD : LOW;
            end
            HOLD: begin
                div_d   = last ? '0 : div_d;
                state_d = last ? IDLE : HOLD;
            end
            default: begin
                div_d   = '0;
                state_d = IDLE;
            end
        endcase
        if (i_abort && state_q != IDLE) begin
            state_d = IDLE;
            div_d   = '0;
        end
    end
    // Outputs are decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge i_clk_p or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sh_en_q  <= 1'b0;
            sh_wrt_q <= 1'b0;
            sh_bit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sclk_q   <= state_d == HIGH;
            cs_n_q   <= state_d == IDLE || state_d == LOAD;
            busy_q   <= state_d != IDLE;
            done_q   <= state_q == HOLD && state_d == IDLE && !i_abort;
            sh_en_q  <= state_d == LOAD || (state_d == HIGH && div_d == DW'(CLK_DIV - 1));
            sh_wrt_q <= state_d == LOAD;
            sh_bit_q <= (state_d == HIGH && state_q != HIGH) ? i_miso : sh_bit_q;
        end
    end
    assign o_sclk   = sclk_q;
    assign o_cs_n   = cs_n_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_sh_en  = sh_en_q;
    assign o_sh_wrt = sh_wrt_q;
    assign o_sh_bit = sh_bit_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: randomized frames through two sequencers (CLK_DIV=4 and CLK_DIV=1),
// each driving a behavioural shifter, checked against frame-level expectations.
module tb_spi_master_ctrl;
    localparam int N     = 20;
    localparam int LAT_A = 1 + (2 * N + 1) * 4;
    localparam int LAT_B = 1 + (2 * N + 1) * 1;
    logic clk = 1'b0, rst_n = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int errors = 0, checks = 0;

    logic start_a = 1'b0, abort_a = 1'b0, miso_a, sh_en_a, sh_wrt_a, sh_bit_a, mosi_a, sclk_a, cs_n_a, busy_a, done_a;
    logic [N-1:0] tx_a = '0, pat_a = '0, sh_a;
    bit loop_a = 1'b1;
    int rises_a = 0, falls_a = 0, shifts_a = 0, dones_a = 0, fb_a = 0, rb_a = 0, sb_a = 0, db_a = 0, qb_a = 0;
    logic psclk_a = 1'b0;
    logic mosi_q_a[$];
    assign miso_a = loop_a ? mosi_a : ((falls_a - fb_a < N) ? pat_a[falls_a - fb_a] : 1'b0);

    logic start_b = 1'b0, abort_b = 1'b0, miso_b, sh_en_b, sh_wrt_b, sh_bit_b, mosi_b, sclk_b, cs_n_b, busy_b, done_b;
    logic [N-1:0] tx_b = '0, sh_b;
    int rises_b = 0, shifts_b = 0, rb_b = 0, sb_b = 0, qb_b = 0;
    logic psclk_b = 1'b0;
    int rcyc_b[$];
    assign miso_b = mosi_b;

    spi_master_ctrl #(.N(N), .CLK_DIV(4)) dut_a (
        .i_clk_p(clk), .i_rst_n(rst_n), .i_start(start_a), .i_abort(abort_a), .i_miso(miso_a),
        .i_sh_bit(sh_a[0]), .o_sh_en(sh_en_a), .o_sh_wrt(sh_wrt_a), .o_sh_bit(sh_bit_a),
        .o_mosi(mosi_a), .o_sclk(sclk_a), .o_cs_n(cs_n_a), .o_busy(busy_a), .o_done(done_a)
    );
    spi_master_ctrl #(.N(N), .CLK_DIV(1)) dut_b (
        .i_clk_p(clk), .i_rst_n(rst_n), .i_start(start_b), .i_abort(abort_b), .i_miso(miso_b),
        .i_sh_bit(sh_b[0]), .o_sh_en(sh_en_b), .o_sh_wrt(sh_wrt_b), .o_sh_bit(sh_bit_b),
        .o_mosi(mosi_b), .o_sclk(sclk_b), .o_cs_n(cs_n_b), .o_busy(busy_b), .o_done(done_b)
    );

    // Behavioural LSB-first shifters: load TX, or shift the MISO sample in at the top.
    always @(posedge clk) if (sh_en_a) sh_a <= sh_wrt_a ? tx_a : {sh_bit_a, sh_a[N-1:1]};
    always @(posedge clk) if (sh_en_b) sh_b <= sh_wrt_b ? tx_b : {sh_bit_b, sh_b[N-1:1]};

    always @(negedge clk) begin
        if (sclk_a && !psclk_a) begin
            rises_a++;
            mosi_q_a.push_back(mosi_a);
        end
        if (!sclk_a && psclk_a) falls_a++;
        if (sh_en_a && !sh_wrt_a) shifts_a++;
        if (done_a) dones_a++;
        psclk_a = sclk_a;
    end
    always @(negedge clk) begin
        if (sclk_b && !psclk_b) begin
            rises_b++;
            rcyc_b.push_back(cyc);
        end
        if (sh_en_b && !sh_wrt_b) shifts_b++;
        psclk_b = sclk_b;
    end

    function automatic logic [N-1:0] mosi_word_a(input int base);
        logic [N-1:0] w;
        for (int i = 0; i < N; i++) w[i] = (base + i < mosi_q_a.size()) ? mosi_q_a[base + i] : 1'bx;
        return w;
    endfunction

    task automatic kick_a(input logic [N-1:0] tx, input logic [N-1:0] pat, input bit loop, output int t0);
        @(negedge clk);
        tx_a = tx; pat_a = pat; loop_a = loop;
        rb_a = rises_a; sb_a = shifts_a; db_a = dones_a; qb_a = mosi_q_a.size(); fb_a = falls_a;
        t0 = cyc;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < 1000 && lat < 0; i++) begin
            if (done_a) lat = cyc - t0 - 1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (sclk_a !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b expected 0", sclk_a); end
        checks++; if (cs_n_a !== 1'b1) begin errors++; $display("FAIL rst_cs_n: got %b expected 1", cs_n_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done_a); end
        checks++; if ({sh_en_a, sh_wrt_a, sh_bit_a} !== 3'b000) begin errors++; $display("FAIL rst_sh: got %b expected 000", {sh_en_a, sh_wrt_a, sh_bit_a}); end
        checks++; if ({sclk_b, cs_n_b, busy_b, done_b, sh_en_b} !== 5'b01000) begin errors++; $display("FAIL rst_b: got %b expected 01000", {sclk_b, cs_n_b, busy_b, done_b, sh_en_b}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_async_reset();
        int t0;
        kick_a(N'($urandom), '0, 1'b1, t0);
        for (int i = 0; i < 100 && !sclk_a; i++) @(negedge clk);
        checks++; if (sclk_a !== 1'b1) begin errors++; $display("FAIL areset_reach_high: got %b expected 1", sclk_a); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({sclk_a, cs_n_a, busy_a, done_a} !== 4'b0100) begin errors++; $display("FAIL areset_ctl: got %b expected 0100", {sclk_a, cs_n_a, busy_a, done_a}); end
        checks++; if ({sh_en_a, sh_wrt_a, sh_bit_a} !== 3'b000) begin errors++; $display("FAIL areset_sh: got %b expected 000", {sh_en_a, sh_wrt_a, sh_bit_a}); end
        @(negedge clk) rst_n = 1'b1;
        repeat (LAT_A + 10) @(negedge clk);
        checks++; if (dones_a - db_a !== 0) begin errors++; $display("FAIL areset_no_done: got %0d expected 0", dones_a - db_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL areset_idle: got %b expected 0", busy_a); end
    endtask

    task automatic test_loopback();
        int t0, lat;
        logic [N-1:0] tx;
        for (int k = 0; k < 3; k++) begin
            tx = (k == 0) ? 20'hA5A5A : N'($urandom);
            kick_a(tx, '0, 1'b1, t0);
            wait_done_a(t0, lat);
            checks++; if (lat !== LAT_A) begin errors++; $display("FAIL loop_latency: got %0d expected %0d", lat, LAT_A); end
            checks++; if (rises_a - rb_a !== N) begin errors++; $display("FAIL loop_rises: got %0d expected %0d", rises_a - rb_a, N); end
            checks++; if (shifts_a - sb_a !== N) begin errors++; $display("FAIL loop_shifts: got %0d expected %0d", shifts_a - sb_a, N); end
            checks++; if (sh_a !== tx) begin errors++; $display("FAIL loop_rx: got %h expected %h", sh_a, tx); end
            checks++; if (mosi_word_a(qb_a) !== tx) begin errors++; $display("FAIL loop_mosi_order: got %h expected %h", mosi_word_a(qb_a), tx); end
            @(negedge clk);
            checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL loop_done_width: got %b expected 0", done_a); end
            checks++; if (dones_a - db_a !== 1) begin errors++; $display("FAIL loop_done_count: got %0d expected 1", dones_a - db_a); end
        end
    endtask

    task automatic test_miso_pattern();
        int t0, lat;
        logic [N-1:0] tx, pat;
        for (int k = 0; k < 2; k++) begin
            tx = N'($urandom);
            pat = (k == 0) ? 20'h0F0F1 : N'($urandom);
            kick_a(tx, pat, 1'b0, t0);
            wait_done_a(t0, lat);
            checks++; if (lat !== LAT_A) begin errors++; $display("FAIL pat_latency: got %0d expected %0d", lat, LAT_A); end
            checks++; if (sh_a !== pat) begin errors++; $display("FAIL pat_rx: got %h expected %h", sh_a, pat); end
            checks++; if (mosi_word_a(qb_a) !== tx) begin errors++; $display("FAIL pat_mosi_order: got %h expected %h", mosi_word_a(qb_a), tx); end
        end
        loop_a = 1'b1;
    endtask

    task automatic test_start_while_busy();
        int t0, lat;
        kick_a(N'($urandom), '0, 1'b1, t0);
        for (int i = 0; i < 100 && !sclk_a; i++) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        wait_done_a(t0, lat);
        checks++; if (lat !== LAT_A) begin errors++; $display("FAIL busy_start_latency: got %0d expected %0d", lat, LAT_A); end
        repeat (20) @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL busy_start_idle: got %b expected 0", busy_a); end
        checks++; if (dones_a - db_a !== 1) begin errors++; $display("FAIL busy_start_frames: got %0d expected 1", dones_a - db_a); end
    endtask

    task automatic test_back_to_back();
        int t0, t1, lat;
        logic [N-1:0] tx;
        tx = N'($urandom);
        @(negedge clk);
        tx_a = tx; loop_a = 1'b1;
        sb_a = shifts_a; db_a = dones_a;
        t0 = cyc;
        start_a = 1'b1;
        @(negedge clk);
        wait_done_a(t0, lat);
        checks++; if (lat !== LAT_A) begin errors++; $display("FAIL b2b_first_latency: got %0d expected %0d", lat, LAT_A); end
        checks++; if ({cs_n_a, busy_a} !== 2'b10) begin errors++; $display("FAIL b2b_gap: got cs_n,busy=%b expected 10", {cs_n_a, busy_a}); end
        t1 = cyc;
        @(negedge clk);
        checks++; if ({cs_n_a, busy_a} !== 2'b11) begin errors++; $display("FAIL b2b_reload: got cs_n,busy=%b expected 11", {cs_n_a, busy_a}); end
        start_a = 1'b0;
        wait_done_a(t1, lat);
        checks++; if (lat !== LAT_A) begin errors++; $display("FAIL b2b_second_latency: got %0d expected %0d", lat, LAT_A); end
        checks++; if (sh_a !== tx) begin errors++; $display("FAIL b2b_rx: got %h expected %h", sh_a, tx); end
        repeat (30) @(negedge clk);
        checks++; if (shifts_a - sb_a !== 2 * N) begin errors++; $display("FAIL b2b_shifts: got %0d expected %0d", shifts_a - sb_a, 2 * N); end
        checks++; if (dones_a - db_a !== 2) begin errors++; $display("FAIL b2b_frames: got %0d expected 2", dones_a - db_a); end
    endtask

    task automatic test_abort();
        int t0, lat, s;
        logic [N-1:0] tx;
        kick_a(N'($urandom), '0, 1'b1, t0);
        for (int i = 0; i < 400 && rises_a - rb_a < 10; i++) @(negedge clk);
        checks++; if ({rises_a - rb_a, sclk_a} !== {32'd10, 1'b1}) begin errors++; $display("FAIL abort_reach: got rises=%0d sclk=%b expected 10,1", rises_a - rb_a, sclk_a); end
        abort_a = 1'b1;
        @(negedge clk) abort_a = 1'b0;
        checks++; if ({busy_a, cs_n_a, sclk_a, sh_en_a} !== 4'b0100) begin errors++; $display("FAIL abort_idle: got busy,cs_n,sclk,sh_en=%b expected 0100", {busy_a, cs_n_a, sclk_a, sh_en_a}); end
        s = shifts_a;
        repeat (LAT_A + 10) @(negedge clk);
        checks++; if (dones_a - db_a !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", dones_a - db_a); end
        checks++; if (shifts_a !== s) begin errors++; $display("FAIL abort_no_shift: got %0d expected %0d", shifts_a, s); end
        start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort_a = 1'b0;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_beats_start: got %b expected 0", busy_a); end
        tx = N'($urandom);
        kick_a(tx, '0, 1'b1, t0);
        wait_done_a(t0, lat);
        checks++; if (lat !== LAT_A) begin errors++; $display("FAIL abort_recover_latency: got %0d expected %0d", lat, LAT_A); end
        checks++; if (sh_a !== tx) begin errors++; $display("FAIL abort_recover_rx: got %h expected %h", sh_a, tx); end
    endtask

    task automatic test_clkdiv1();
        int t0, lat, bad;
        logic [N-1:0] tx;
        for (int k = 0; k < 2; k++) begin
            tx = N'($urandom);
            @(negedge clk);
            tx_b = tx;
            rb_b = rises_b; sb_b = shifts_b; qb_b = rcyc_b.size();
            t0 = cyc;
            start_b = 1'b1;
            @(negedge clk) start_b = 1'b0;
            lat = -1;
            for (int i = 0; i < 500 && lat < 0; i++) begin
                if (done_b) lat = cyc - t0 - 1;
                else @(negedge clk);
            end
            checks++; if (lat !== LAT_B) begin errors++; $display("FAIL div1_latency: got %0d expected %0d", lat, LAT_B); end
            checks++; if (rises_b - rb_b !== N) begin errors++; $display("FAIL div1_rises: got %0d expected %0d", rises_b - rb_b, N); end
            checks++; if (shifts_b - sb_b !== N) begin errors++; $display("FAIL div1_shifts: got %0d expected %0d", shifts_b - sb_b, N); end
            checks++; if (sh_b !== tx) begin errors++; $display("FAIL div1_rx: got %h expected %h", sh_b, tx); end
            bad = 0;
            for (int i = qb_b + 1; i < rcyc_b.size(); i++) if (rcyc_b[i] - rcyc_b[i-1] != 2) bad++;
            checks++; if (bad !== 0) begin errors++; $display("FAIL div1_sclk_period: got %0d irregular periods expected 0", bad); end
        end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_loopback();
        test_miso_pattern();
        test_start_while_busy();
        test_back_to_back();
        test_abort();
        test_clkdiv1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
